// File: rtl/comm_pkg.sv
// Shared types and constants for the comm_arbiter block and its sub-modules.
package comm_pkg;

    localparam int BYTE_W             = 8;
    localparam int OWNER_W            = 3;
    localparam int TIMEOUT_CYCLES_DEF = 4096;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_e;

    function automatic logic [OWNER_W-1:0] wrap_inc(input logic [OWNER_W-1:0] idx,
                                                    input int modulus);
        if (int'(idx) >= modulus - 1) return '0;
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/comm_arbiter_if.sv
// Requester / transmitter bus of comm_arbiter.
// The lock vector exists only when COMM_ARBITER_LOCK_EN is defined.
interface comm_arbiter_if #(parameter int NUM_REQ = 4);
    import comm_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [BYTE_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        grant;
    logic [BYTE_W-1:0]         tx_data;
    logic                      tx_start;
    logic                      tx_busy;
    logic                      tx_done;
    logic [OWNER_W-1:0]        owner;
    logic                      timeout;

`ifdef COMM_ARBITER_LOCK_EN
    logic [NUM_REQ-1:0]        lock;

    modport master (
        input  req, req_data, tx_busy, tx_done, lock,
        output grant, tx_data, tx_start, owner, timeout
    );
    modport slave (
        output req, req_data, tx_busy, tx_done, lock,
        input  grant, tx_data, tx_start, owner, timeout
    );
`else
    modport master (
        input  req, req_data, tx_busy, tx_done,
        output grant, tx_data, tx_start, owner, timeout
    );
    modport slave (
        output req, req_data, tx_busy, tx_done,
        input  grant, tx_data, tx_start, owner, timeout
    );
`endif

endinterface

// File: rtl/rr_select.sv
// Combinational round-robin pick: first set request at or after rr_ptr_i, wrapping at NUM_REQ.
module rr_select
    import comm_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [OWNER_W-1:0] rr_ptr_i,
    output logic [OWNER_W-1:0] winner_o,
    output logic               valid_o
);

    logic [2*NUM_REQ-1:0] rot;
    int                   sum;

    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        sum      = 0;
        rot      = {req_i, req_i} >> rr_ptr_i;
        // Scan from the far end so the closest request to rr_ptr_i wins last.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = int'(rr_ptr_i) + i;
                if (sum >= NUM_REQ) sum = sum - NUM_REQ;
                winner_o = OWNER_W'(sum);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/comm_arbiter.sv
// Round-robin arbiter sharing one serial byte transmitter among NUM_REQ requesters.
// Optional: COMM_ARBITER_LOCK_EN keeps ownership with a locked requester across frames.
//
// state        | meaning
// ST_IDLE      | evaluate requests, latch winner index and byte
// ST_ISSUE     | wait for transmitter idle, then pulse tx_start/grant
// ST_WAIT_DONE | count until tx_done or timeout, then advance rr pointer
module comm_arbiter
    import comm_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           reset,
    comm_arbiter_if.master bus
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e               state_q, state_d;
    logic [OWNER_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    logic [BYTE_W-1:0]    tx_data_q, tx_data_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;

    logic [OWNER_W-1:0]   sel_idx;
    logic                 sel_valid;
    logic [BYTE_W-1:0]    sel_byte;
    logic [NUM_REQ-1:0]   owner_mask;
    logic [OWNER_W-1:0]   next_ptr;
    logic                 hold_owner;
    logic [NUM_REQ-1:0]   grant_d;
    logic                 tx_start_d;

    rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
        .req_i    (bus.req),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (sel_idx),
        .valid_o  (sel_valid)
    );

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == OWNER_W'(i)) sel_byte = bus.req_data[BYTE_W*i +: BYTE_W];
        end
    end

    assign owner_mask = NUM_REQ'(1) << owner_q;
    assign next_ptr   = wrap_inc(owner_q, NUM_REQ);

`ifdef COMM_ARBITER_LOCK_EN
    assign hold_owner = |(bus.lock & owner_mask);
`else
    assign hold_owner = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            owner_q   <= '0;
            tx_data_q <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        tx_data_d  = tx_data_q;
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
        grant_d    = '0;
        tx_start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (sel_valid) begin
                    owner_d   = sel_idx;
                    tx_data_d = sel_byte;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A reset cycle must not leak a grant for the frame being abandoned.
                if (!bus.tx_busy && !reset) begin
                    tx_start_d = 1'b1;
                    grant_d    = owner_mask;
                    cnt_d      = '0;
                    state_d    = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.tx_done) begin
                    rr_ptr_d = hold_owner ? owner_q : next_ptr;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    rr_ptr_d  = next_ptr;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.grant    = grant_d;
    assign bus.tx_start = tx_start_d;
    assign bus.owner    = owner_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_comm_arbiter.sv
// Directed bench for comm_arbiter: vector table plus multi-cycle corner sequences.
module tb_comm_arbiter;

    localparam int NR = 4;

    typedef struct packed {
        logic [3:0]  req;
        logic        busy;
        logic        done;
        logic [16:0] exp;   // {grant, tx_start, owner, tx_data, timeout}
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        tx_busy;
    logic        tx_done;
    logic        found;
    logic [3:0]  rr_exp [0:4];
    vec_t        vt[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    comm_arbiter_if #(.NUM_REQ(NR)) ifa ();
    comm_arbiter_if #(.NUM_REQ(NR)) ifb ();

    assign ifa.req      = req;
    assign ifa.req_data = req_data;
    assign ifa.tx_busy  = tx_busy;
    assign ifa.tx_done  = tx_done;
    assign ifb.req      = req;
    assign ifb.req_data = req_data;
    assign ifb.tx_busy  = tx_busy;
    assign ifb.tx_done  = tx_done;

`ifdef COMM_ARBITER_LOCK_EN
    logic [3:0] lock;
    assign ifa.lock = lock;
    assign ifb.lock = lock;
`endif

    comm_arbiter #(.NUM_REQ(NR)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.master)
    );

    comm_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(16)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.master)
    );

    function automatic logic [16:0] obs_a();
        return {ifa.grant, ifa.tx_start, ifa.owner, ifa.tx_data, ifa.timeout};
    endfunction

    function automatic logic [16:0] obs_b();
        return {ifb.grant, ifb.tx_start, ifb.owner, ifb.tx_data, ifb.timeout};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive just after the active edge, return at mid-cycle for sampling.
    task automatic step(input logic [3:0] r, input logic b, input logic d);
        @(posedge clk);
        #1;
        req     = r;
        tx_busy = b;
        tx_done = d;
        #4;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic add(input logic [3:0] r, input logic b, input logic d, input logic [3:0] g,
                       input logic s, input logic [2:0] o, input logic [7:0] dt);
        vt.push_back(vec_t'({r, b, d, g, s, o, dt, 1'b0}));
    endtask

    task automatic wait_start(input logic [3:0] r);
        found = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            step(r, 1'b0, 1'b0);
            found = ifa.tx_start;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got still running want finished");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        req      = '0;
        tx_busy  = 1'b0;
        tx_done  = 1'b0;
        req_data = 32'h4433_22A5;
`ifdef COMM_ARBITER_LOCK_EN
        lock     = '0;
`endif
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

        //   req      busy  done  grant    start owner  data
        add(4'b0001, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 8'h00);
        add(4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 3'd0, 8'hA5);
        add(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 8'hA5);
        add(4'b0100, 1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 8'hA5);
        add(4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 8'hA5);
        add(4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd2, 8'h33);
        add(4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0, 3'd2, 8'h33);
        add(4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 3'd2, 8'h33);
        add(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 3'd2, 8'h33);
        add(4'b0011, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd2, 8'h33);
        add(4'b0011, 1'b0, 1'b1, 4'b0001, 1'b1, 3'd0, 8'hA5);
        add(4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 8'hA5);
        add(4'b0010, 1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 8'hA5);
        add(4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd0, 8'hA5);
        add(4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 3'd1, 8'h22);
        add(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 3'd1, 8'h22);
        add(4'b1000, 1'b0, 1'b1, 4'b0000, 1'b0, 3'd1, 8'h22);
        add(4'b0000, 1'b0, 1'b0, 4'b1000, 1'b1, 3'd3, 8'h44);
        add(4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 3'd3, 8'h44);
        add(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd3, 8'h44);
        add(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 3'd3, 8'h44);

        step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b0);
        chk("reset_state_a", 32'(obs_a()), 32'd0);
        chk("reset_state_b", 32'(obs_b()), 32'd0);
        reset = 1'b0;

        foreach (vt[i]) begin
            step(vt[i].req, vt[i].busy, vt[i].done);
            chk($sformatf("vec%0d", i), 32'(obs_a()), 32'(vt[i].exp));
        end

        // All four requesting, tx_done 20 cycles after each start.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            wait_start(4'b1111);
            chk("rr_start_seen", 32'(found), 32'd1);
            chk($sformatf("rr_grant%0d", k), 32'(ifa.grant), 32'(rr_exp[k]));
            repeat (19) step(4'b1111, 1'b0, 1'b0);
            step(4'b1111, 1'b0, 1'b1);
        end

        // rr pointer is 1 here; reset must bring it back to 0.
        do_reset();
        step(4'b0011, 1'b0, 1'b0);
        step(4'b0011, 1'b0, 1'b0);
        chk("rr_after_reset", 32'({ifa.grant, ifa.tx_start}), 32'({4'b0001, 1'b1}));
        step(4'b0000, 1'b0, 1'b1);

        // Transmitter busy for five ISSUE cycles.
        do_reset();
        step(4'b0100, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(4'b0100, 1'b1, 1'b0);
            chk($sformatf("busy_hold%0d", i), 32'({ifa.grant, ifa.tx_start}), 32'd0);
        end
        step(4'b0100, 1'b0, 1'b0);
        chk("busy_release", 32'({ifa.grant, ifa.tx_start, ifa.owner}), 32'({4'b0100, 1'b1, 3'd2}));
        step(4'b0000, 1'b0, 1'b1);

        // Timeout on the TIMEOUT_CYCLES=16 instance, then deferred request granted.
        do_reset();
        step(4'b0001, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b0);
        chk("tmo_start", 32'(ifb.tx_start), 32'd1);
        for (int n = 1; n <= 16; n++) begin
            step(4'b0010, 1'b0, 1'b0);
            chk($sformatf("tmo_quiet%0d", n), 32'({ifb.timeout, ifb.grant}), 32'd0);
        end
        step(4'b0010, 1'b0, 1'b0);
        chk("tmo_pulse", 32'({ifb.timeout, ifb.grant}), 32'({1'b1, 4'b0000}));
        step(4'b0010, 1'b0, 1'b0);
        chk("tmo_next_grant", 32'({ifb.timeout, ifb.grant, ifb.tx_start, ifb.owner}),
            32'({1'b0, 4'b0010, 1'b1, 3'd1}));

        // tx_done on the expiry cycle counts as done.
        for (int n = 1; n <= 15; n++) step(4'b0000, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0000, 1'b0, 1'b0);
        chk("done_at_expiry_no_tmo", 32'(ifb.timeout), 32'd0);
        step(4'b0001, 1'b0, 1'b0);
        chk("done_at_expiry_tmo_later", 32'(ifb.timeout), 32'd0);
        step(4'b0001, 1'b0, 1'b0);
        chk("done_at_expiry_regrant", 32'({ifb.grant, ifb.tx_start}), 32'({4'b0001, 1'b1}));

        // Reset three cycles into WAIT_DONE.
        do_reset();
        step(4'b0010, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b0);
        chk("rstmid_start", 32'({ifa.grant, ifa.tx_start, ifa.owner}), 32'({4'b0010, 1'b1, 3'd1}));
        repeat (3) step(4'b0000, 1'b0, 1'b0);
        reset = 1'b1;
        step(4'b0000, 1'b0, 1'b0);
        chk("rstmid_outputs", 32'(obs_a()), 32'd0);
        reset = 1'b0;
        step(4'b0000, 1'b0, 1'b0);
        chk("rstmid_abandon", 32'(obs_a()), 32'd0);
        step(4'b1000, 1'b0, 1'b0);
        step(4'b1000, 1'b0, 1'b0);
        chk("rstmid_regrant", 32'(obs_a()), 32'({4'b1000, 1'b1, 3'd3, 8'h44, 1'b0}));
        step(4'b0000, 1'b0, 1'b1);

`ifdef COMM_ARBITER_LOCK_EN
        do_reset();
        lock = 4'b0001;
        for (int f = 0; f < 4; f++) begin
            wait_start(4'b0011);
            chk("lock_start_seen", 32'(found), 32'd1);
            chk($sformatf("lock_grant%0d", f), 32'(ifa.grant), (f < 3) ? 32'd1 : 32'd2);
            step(4'b0011, 1'b0, 1'b0);
            if (f == 2) lock = 4'b0000;
            step(4'b0011, 1'b0, 1'b1);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
